hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It decides each cycle whether IF, ID and EX advance, hold or are flushed. It drives the `clear` input of the ID/EX pipeline register, the enables of the PC and IF/ID registers, and the EX-stage forwarding selects. It also sequences multi-cycle EX operations (mult/div) with an internal FSM and down-counter.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_md_timer.sv | 63 ++++++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
package hazard_pkg;

  // Width of the multi-cycle down-counter.
  localparam int CNT_W = 4;

  // Multi-cycle sequencer states.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // EX operand select encodings.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // True when s names the register r and r is not $zero.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] s);
    return (r != 5'd0) && (r == s);
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Multi-cycle (mult/div) sequencer: holds EX for MD_LATENCY-1 cycles, then
// lets the op advance on the following cycle.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MultiCycleE,
  output logic md_stall,
  output logic busy
);

  localparam bit              MD_ENABLED = (MD_LATENCY > 1);
  localparam bit              MD_SHORT   = (MD_LATENCY == 2);
  localparam logic [CNT_W-1:0] CNT_LOAD  = MD_ENABLED ? CNT_W'(MD_LATENCY - 2) : '0;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_entry;

  // A new multi-cycle op starts stalling in the cycle it first appears in EX.
  assign md_entry = (state_q == RUN) && MultiCycleE && MD_ENABLED;

  // Stall and busy are identical; both are suppressed while reset is held.
  assign md_stall = reset && (md_entry || (state_q == MD_WAIT));
  assign busy     = md_stall;

  // Next-state and counter computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (md_entry) begin
          cnt_d   = CNT_LOAD;
          state_d = MD_SHORT ? MD_DONE : MD_WAIT;
        end
      end
      MD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_DONE;
      end
      MD_DONE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage MIPS core: stall, flush and
// forwarding decisions for IF/ID/EX.
// Build option: define HAZARD_FWD_EN to enable EX-stage forwarding; without
// it, RAW hazards on EX/MEM producers stall the instruction in ID instead.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MultiCycleE,
  input  logic       BranchTakenD,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       Busy
);

  logic       md_stall;
  logic       lwstall;
  logic       data_stall;
  logic [1:0] fwd_a, fwd_b;

  hazard_md_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clk         (clk),
    .reset       (reset),
    .MultiCycleE (MultiCycleE),
    .md_stall    (md_stall),
    .busy        (Busy)
  );

  // Load in EX whose result is needed by the instruction in ID.
  assign lwstall = MemtoRegE && RegWriteE &&
                   (reg_match(WriteRegE, rsD) || reg_match(WriteRegE, rtD));

`ifdef HAZARD_FWD_EN
  // MEM result is newer than WB, so it wins when both match.
  assign fwd_a = (RegWriteM && reg_match(WriteRegM, rsE)) ? FWD_MEM :
                 (RegWriteW && reg_match(WriteRegW, rsE)) ? FWD_WB  : FWD_NONE;
  assign fwd_b = (RegWriteM && reg_match(WriteRegM, rtE)) ? FWD_MEM :
                 (RegWriteW && reg_match(WriteRegW, rtE)) ? FWD_WB  : FWD_NONE;
  assign data_stall = lwstall;
`else
  logic raw_stall;
  logic unused_fwd_inputs;

  // Without forwarding, any producer still in EX or MEM must drain first.
  assign raw_stall = (RegWriteE && (reg_match(WriteRegE, rsD) || reg_match(WriteRegE, rtD))) ||
                     (RegWriteM && (reg_match(WriteRegM, rsD) || reg_match(WriteRegM, rtD)));
  assign fwd_a      = FWD_NONE;
  assign fwd_b      = FWD_NONE;
  assign data_stall = lwstall || raw_stall;
  assign unused_fwd_inputs = ^{rsE, rtE, WriteRegW, RegWriteW};
`endif

  // Priority resolution: MD stall > data stall > taken-branch flush.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    if (reset) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (md_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (data_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (BranchTakenD) begin
        FlushD = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (MD_LATENCY 4, 2, 1) share
// one stimulus stream; a reference model predicts each one's outputs.
module tb_hazard_ctrl;

  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{4, 2, 1};

  typedef struct packed {
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic [1:0] fwd_a, fwd_b;
    logic       busy;
  } outs_t;

  typedef outs_t [NDUT-1:0] exp_t;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, w_e, w_m, w_w;
    logic       rw_e, rw_m, rw_w, mem_e, mc_e, br_d;
  } in_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiCycleE, BranchTakenD;

  logic [NDUT-1:0] stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy;
  logic [1:0]      fwd_a [NDUT];
  logic [1:0]      fwd_b [NDUT];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: remaining MD stall cycles and pending "done" cycle.
  int rem  [NDUT];
  bit done [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hazard_ctrl #(.MD_LATENCY(LATS[g])) u_dut (
      .clk          (clk),
      .reset        (reset),
      .rsD          (rsD),
      .rtD          (rtD),
      .rsE          (rsE),
      .rtE          (rtE),
      .WriteRegE    (WriteRegE),
      .WriteRegM    (WriteRegM),
      .WriteRegW    (WriteRegW),
      .RegWriteE    (RegWriteE),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .MemtoRegE    (MemtoRegE),
      .MultiCycleE  (MultiCycleE),
      .BranchTakenD (BranchTakenD),
      .StallF       (stall_f[g]),
      .StallD       (stall_d[g]),
      .StallE       (stall_e[g]),
      .FlushD       (flush_d[g]),
      .FlushE       (flush_e[g]),
      .FlushM       (flush_m[g]),
      .ForwardAE    (fwd_a[g]),
      .ForwardBE    (fwd_b[g]),
      .Busy         (busy[g])
    );
  end

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got SF%b SD%b SE%b FD%b FE%b FM%b FA%b FB%b BSY%b, want SF%b SD%b SE%b FD%b FE%b FM%b FA%b FB%b BSY%b",
               name, act.stall_f, act.stall_d, act.stall_e, act.flush_d, act.flush_e,
               act.flush_m, act.fwd_a, act.fwd_b, act.busy,
               exp.stall_f, exp.stall_d, exp.stall_e, exp.flush_d, exp.flush_e,
               exp.flush_m, exp.fwd_a, exp.fwd_b, exp.busy);
    end
  endtask

  function automatic bit hit(input logic [4:0] r, input logic [4:0] s);
    return (r != 0) && (r == s);
  endfunction

  function automatic logic [1:0] fwd_sel(input in_t x, input logic [4:0] src);
`ifdef HAZARD_FWD_EN
    if (x.rw_m && hit(x.w_m, src)) return 2'b10;
    if (x.rw_w && hit(x.w_w, src)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic in_t idle();
    in_t x;
    x = '{rst_n: 1'b1, default: '0};
    return x;
  endfunction

  // Apply one cycle of stimulus and push the predicted outputs of every DUT.
  task automatic step(input in_t x);
    exp_t e;
    bit   md, lw, ds;
    @(posedge clk);
    #1;
    reset = x.rst_n;  rsD = x.rs_d;  rtD = x.rt_d;  rsE = x.rs_e;  rtE = x.rt_e;
    WriteRegE = x.w_e;  WriteRegM = x.w_m;  WriteRegW = x.w_w;
    RegWriteE = x.rw_e; RegWriteM = x.rw_m; RegWriteW = x.rw_w;
    MemtoRegE = x.mem_e; MultiCycleE = x.mc_e; BranchTakenD = x.br_d;

    lw = x.mem_e && x.rw_e && (hit(x.w_e, x.rs_d) || hit(x.w_e, x.rt_d));
    ds = lw;
`ifndef HAZARD_FWD_EN
    ds = ds || (x.rw_e && (hit(x.w_e, x.rs_d) || hit(x.w_e, x.rt_d)))
            || (x.rw_m && (hit(x.w_m, x.rs_d) || hit(x.w_m, x.rt_d)));
`endif

    for (int i = 0; i < NDUT; i++) begin
      // An op occupies EX for LATS[i] cycles: LATS[i]-1 stalls, then one exit cycle.
      md = 1'b0;
      if (!x.rst_n) begin
        rem[i] = 0; done[i] = 1'b0;
      end else if (rem[i] > 0) begin
        md = 1'b1; rem[i]--; if (rem[i] == 0) done[i] = 1'b1;
      end else if (done[i]) begin
        done[i] = 1'b0;
      end else if (x.mc_e && LATS[i] > 1) begin
        md = 1'b1; rem[i] = LATS[i] - 2; if (rem[i] == 0) done[i] = 1'b1;
      end

      e[i] = '0;
      if (x.rst_n) begin
        e[i].fwd_a = fwd_sel(x, x.rs_e);
        e[i].fwd_b = fwd_sel(x, x.rt_e);
        e[i].busy  = md;
        if (md) begin
          e[i].stall_f = 1; e[i].stall_d = 1; e[i].stall_e = 1; e[i].flush_m = 1;
        end else if (ds) begin
          e[i].stall_f = 1; e[i].stall_d = 1; e[i].flush_e = 1;
        end else if (x.br_d) begin
          e[i].flush_d = 1;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor: compare each DUT against the oldest prediction on the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    outs_t a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cyc++;
      assert (!(MemtoRegE && MultiCycleE));
      for (int i = 0; i < NDUT; i++) begin
        a = '{stall_f[i], stall_d[i], stall_e[i], flush_d[i], flush_e[i],
              flush_m[i], fwd_a[i], fwd_b[i], busy[i]};
        check($sformatf("lat%0d_cyc%0d", LATS[i], cyc), a, e[i]);
      end
    end
  end

  initial begin
    in_t x;
    int  mc_hold;
    for (int i = 0; i < NDUT; i++) begin rem[i] = 0; done[i] = 1'b0; end
    x = idle(); x.rst_n = 1'b0;
    reset = 1'b0;
    {rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiCycleE, BranchTakenD} = '0;

    // Reset with live hazard inputs: everything must read zero.
    x.mc_e = 1; x.rw_m = 1; x.w_m = 5; x.rs_e = 5; x.br_d = 1;
    step(x); step(x);
    step(idle());

    // Load-use on $8, then the load drains to MEM and WB.
    x = idle(); x.mem_e = 1; x.rw_e = 1; x.w_e = 8; x.rs_d = 8; step(x);
    x = idle(); x.rw_m = 1; x.w_m = 8; x.rs_d = 8; step(x);
    x = idle(); x.rw_w = 1; x.w_w = 8; x.rs_e = 8; step(x);
    // Load into $0 never stalls.
    x = idle(); x.mem_e = 1; x.rw_e = 1; x.w_e = 0; x.rs_d = 0; x.rt_d = 0; step(x);

    // Multi-cycle op held in EX for four cycles, then gone.
    x = idle(); x.mc_e = 1; x.br_d = 1;
    repeat (4) step(x);
    step(idle()); step(idle());

    // Taken branch during a load-use stall, then alone.
    x = idle(); x.br_d = 1; x.mem_e = 1; x.rw_e = 1; x.w_e = 3; x.rt_d = 3; step(x);
    x = idle(); x.br_d = 1; step(x);

    // Forwarding priority: MEM over WB, then WB alone.
    x = idle(); x.rw_m = 1; x.rw_w = 1; x.w_m = 5; x.w_w = 5; x.rs_e = 5; x.rt_e = 5; step(x);
    x.rw_m = 0; step(x);
    // Plain ALU producer in EX feeding ID.
    x = idle(); x.rw_e = 1; x.w_e = 6; x.rs_d = 6; step(x);

    // Reset in the second MD_WAIT cycle abandons the op.
    x = idle(); x.mc_e = 1;
    step(x); step(x);
    x.rst_n = 0; step(x);
    step(idle()); step(idle());

    // Randomized traffic with small register numbers so matches are common.
    mc_hold = 0;
    repeat (600) begin
      x = idle();
      x.rs_d = 5'($urandom_range(0, 3)); x.rt_d = 5'($urandom_range(0, 3));
      x.rs_e = 5'($urandom_range(0, 3)); x.rt_e = 5'($urandom_range(0, 3));
      x.w_e  = 5'($urandom_range(0, 3)); x.w_m  = 5'($urandom_range(0, 3));
      x.w_w  = 5'($urandom_range(0, 3));
      x.rw_e = 1'($urandom_range(0, 1)); x.rw_m = 1'($urandom_range(0, 1));
      x.rw_w = 1'($urandom_range(0, 1)); x.br_d = ($urandom_range(0, 3) == 0);
      if (mc_hold == 0 && $urandom_range(0, 7) == 0) mc_hold = $urandom_range(1, 6);
      if (mc_hold > 0) begin
        x.mc_e = 1; mc_hold--;
      end else begin
        x.mem_e = ($urandom_range(0, 2) == 0);
      end
      x.rst_n = ($urandom_range(0, 49) != 0);
      step(x);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
